// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the div_ctrl clock-divider controller.
package div_ctrl_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } state_t;

   localparam int DIV_MIN   = 2;
   localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/div_ctrl_core.sv
// Counter and waveform generator: counts 0..ratio-1, drives div_clk/div_tick as
// flops aligned with the counter, and holds at period end while gate is low.
module div_ctrl_core
   import div_ctrl_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int DEF_DIV = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] ratio,
   input  logic             gate,
   output logic             wrap,
   output logic             div_clk,
   output logic             div_tick
);

   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEF_LAST = CNT_W'(DEF_DIV - 1);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nxt;
   logic [CNT_W-1:0] half;
   logic [CNT_W-1:0] last;
   logic             held;

   // held keeps the period-end condition true while stopped, even if the ratio
   // changes underneath the frozen counter.
   assign half      = ratio >> 1;
   assign last      = ratio - ONE;
   assign count_nxt = count + ONE;
   assign wrap      = held || (count == last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= DEF_LAST;
         held     <= 1'b0;
         div_clk  <= 1'b0;
         div_tick <= 1'b0;
      end else if (wrap) begin
         if (gate) begin
            count    <= '0;
            held     <= 1'b0;
            div_clk  <= 1'b1;
            div_tick <= 1'b1;
         end else begin
            held     <= 1'b1;
            div_clk  <= 1'b0;
            div_tick <= 1'b0;
         end
      end else begin
         count    <= count_nxt;
         div_clk  <= (count_nxt < half);
         div_tick <= 1'b0;
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// Runtime-programmable clock divider with valid/ready ratio reconfiguration applied
// only at period boundaries. Define DIV_CTRL_GATE_EN to add the run_en gating port.
module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int DEF_DIV = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             busy,
   output logic [CNT_W-1:0] cur_div,
   output logic             div_clk,
   output logic             div_tick
`ifdef DIV_CTRL_GATE_EN
   ,
   input  logic             run_en
`endif
);

   localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(DIV_MIN);
   localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEF_DIV);

   if (DEF_DIV < DIV_MIN || DEF_DIV > (2 ** CNT_W) - 1) begin : g_bad_def_div
      $error("div_ctrl: DEF_DIV must lie in 2..2^CNT_W-1");
   end

   state_t           state;
   state_t           next_state;
   logic [CNT_W-1:0] pend_div;
   logic             gate;
   logic             wrap;
   logic             xfer;
   logic             div_ok;

`ifdef DIV_CTRL_GATE_EN
   assign gate = run_en;
`else
   assign gate = 1'b1;
`endif

   assign xfer   = cfg_valid && cfg_ready;
   assign div_ok = (cfg_div >= MIN_DIV);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         RUN:     if (xfer && div_ok) next_state = PEND;
         PEND:    if (wrap) next_state = RUN;
         default: next_state = RUN;
      endcase
   end

   always_comb begin
      cfg_ready = 1'b0;
      busy      = 1'b0;
      case (state)
         RUN:     cfg_ready = 1'b1;
         PEND:    busy = 1'b1;
         default: cfg_ready = 1'b1;
      endcase
   end

   // The pending ratio only moves into cur_div on the wrap edge, so a transfer
   // landing in a wrap cycle waits for the following wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_div <= '0;
         cur_div  <= DEF_VAL;
         cfg_err  <= 1'b0;
      end else begin
         cfg_err <= xfer && !div_ok;
         if (xfer && div_ok) begin
            pend_div <= cfg_div;
         end
         if (state == PEND && wrap) begin
            cur_div <= pend_div;
         end
      end
   end

   div_ctrl_core #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .ratio    (cur_div),
      .gate     (gate),
      .wrap     (wrap),
      .div_clk  (div_clk),
      .div_tick (div_tick)
   );

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Runtime-programmable clock-divider controller. It generates a divided clock `div_clk` and a one-cycle `div_tick` strobe from `clk`. The divide ratio is reconfigured through a valid/ready handshake. A new ratio is applied only at a period boundary, so `div_clk` never produces a runt pulse. It sits between the configuration register block and any logic clocked or enabled by the divided clock.

Parameters:
- CNT_W, 16: width of the ratio and the internal counter.
- DEF_DIV, 6: ratio loaded at reset. Elaboration error if outside 2..2^CNT_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  new ratio request
- cfg_div  in  CNT_W  requested ratio
- cfg_ready  out  1  controller can accept a request
- cfg_err  out  1  one-cycle pulse: request rejected (ratio < 2)
- busy  out  1  accepted ratio waiting for boundary
- cur_div  out  CNT_W  ratio currently in effect
- div_clk  out  1  divided clock, registered
- div_tick  out  1  one-cycle pulse, high in the first cycle of each div_clk high phase
- run_en  in  1  only present with DIV_CTRL_GATE_EN

Behaviour:
- One clock; reset is asynchronous and active-high. All flops clear immediately on rst.
- Reset values:
  - div_clk=0, div_tick=0, cfg_err=0, busy=0.
  - cfg_ready=1 (state RUN), cur_div=DEF_DIV.
  - counter=DEF_DIV-1 (last low cycle); pending ratio discarded.
- Waveform, with D=cur_div and H=D>>1:
  - Counter runs 0..D-1 and wraps to 0 after D-1.
  - div_clk is high while counter is 0..H-1 and low while counter is H..D-1.
  - Even D gives 50% duty. Odd D gives H cycles high and H+1 low.
  - div_clk and div_tick are flop outputs, aligned with the counter value.
- First cycle after rst deasserts: counter=0, div_clk=1, div_tick=1.
- States:
  - RUN: cfg_ready=1, busy=0.
  - PEND: cfg_ready=0, busy=1.
- Handshake: a transfer occurs when cfg_valid and cfg_ready are both high.
  - cfg_div < 2: no state change. cfg_err=1 for exactly the following cycle.
  - Otherwise: latch cfg_div into the pending register and go RUN→PEND.
  - cfg_div equal to cur_div is legal and follows the same path.
- PEND→RUN in the wrap cycle (counter==D-1 → 0). In that cycle:
  - cur_div takes the pending value.
  - The new period starts at counter=0 with the new D and H.
- A transfer in the same cycle as a wrap is applied at the following wrap, never the current one.
- Latency from accept to the new period: between 1 and D_old cycles.
- cfg_valid while cfg_ready=0 is ignored. The requester must hold it until ready.
- Arithmetic: all compares are unsigned CNT_W-bit. No overflow is possible because D ≤ 2^CNT_W-1.

Optional Feature:
DIV_CTRL_GATE_EN.
- With the macro, the run_en port exists.
  - run_en low: the current period completes, then the counter holds at D-1 with div_clk=0 and no div_tick.
  - Pending ratio changes still apply at that final wrap.
  - run_en high again: the next cycle starts a period (counter=0, div_tick=1).
- Without the macro: no port; the block is always running.

Decomposition:
- Package div_ctrl_pkg holds:
  - the state enum (RUN, PEND)
  - DIV_MIN=2
  - the default CNT_W constant
- One sub-module, div_ctrl_core: counter and waveform generator.
  - Inputs: ratio, gate. Output: a wrap strobe.
  - The top module holds the handshake FSM and the pending/current ratio registers.

Test Plan:
- Reset release, DEF_DIV=6:
  - div_clk is 1 for 3 cycles, then 0 for 3.
  - div_tick pulses in cycle 1 after rst release, then every 6 cycles.
  - cur_div=6.
- cfg_div=5 accepted at counter=1:
  - cfg_ready drops and busy=1 until the wrap.
  - The current 6-cycle period completes.
  - Then 2 cycles high, 3 cycles low repeat; cur_div=5 from the wrap cycle.
- cfg_div=0, then cfg_div=1:
  - cfg_err pulses one cycle each time.
  - cfg_ready stays 1; waveform and cur_div unchanged.
- cfg_div=4 transferred exactly in the wrap cycle: one more full 6-cycle period, then a 4-cycle period (2 high, 2 low).
- rst asserted mid-cycle while in PEND:
  - div_clk, div_tick and busy go 0 immediately.
  - After release, ratio is 6; the pending ratio is lost.
- With DIV_CTRL_GATE_EN:
  - run_en dropped in the high phase: the period finishes, div_clk stays 0 with no ticks.
  - run_en raised: div_tick=1 and div_clk=1 the next cycle.
